// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: next-address selection, ROM bank select,
// and run/wait-input/ROM-bubble/halt state with the commit stall it implies.
module pc_sequencer #(
  parameter int PC_WIDTH      = 10,
  parameter int ROM_SEL_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               jump,
  input  logic                     branch,
  input  logic                     zero,
  input  logic                     halt,
  input  logic                     input_flag,
  input  logic                     change_rom,
  input  logic [15:0]              imm,
  input  logic [25:0]              jump_addr,
  input  logic [31:0]              reg_target,
  input  logic                     input_confirm,
  output logic [PC_WIDTH-1:0]      pc,
  output logic [PC_WIDTH-1:0]      pc_plus1,
  output logic [ROM_SEL_WIDTH-1:0] rom_sel,
  output logic                     stall,
  output logic                     halted,
  output logic                     waiting_input
);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_WAIT_IN    = 3'd1,
    S_IN_COMMIT  = 3'd2,
    S_ROM_BUBBLE = 3'd3,
    S_HALTED     = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [PC_WIDTH-1:0]      r_pc;
  logic [PC_WIDTH-1:0]      w_pc_nxt;
  logic [ROM_SEL_WIDTH-1:0] r_rom_sel;
  logic [ROM_SEL_WIDTH-1:0] w_rom_sel_nxt;
  logic                     w_stall;

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_edge_q;
  logic                     w_confirm_edge;

  logic [PC_WIDTH-1:0]      w_pc_plus1;
  logic [31:0]              w_imm_sext;
  logic [PC_WIDTH-1:0]      w_branch_tgt;
  logic [PC_WIDTH-1:0]      w_run_next_pc;
  logic                     w_unused_bits;

  // Upper operand bits are architecturally don't-care for this address width.
  assign w_unused_bits = ^{jump_addr, reg_target};

  assign w_pc_plus1     = r_pc + PC_WIDTH'(1);
  assign w_imm_sext     = {{16{imm[15]}}, imm};
  assign w_branch_tgt   = w_pc_plus1 + w_imm_sext[PC_WIDTH-1:0];
  assign w_confirm_edge = r_sync2 & ~r_edge_q;

  // Confirm button synchronizer and rising-edge detector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_edge_q <= 1'b0;
    end else begin
      r_sync1  <= input_confirm;
      r_sync2  <= r_sync1;
      r_edge_q <= r_sync2;
    end
  end

  // Sequential-state next-PC choice, highest priority first.
  always_comb begin
    w_run_next_pc = w_pc_plus1;
    if (jump == 2'b10) begin
      w_run_next_pc = reg_target[PC_WIDTH-1:0];
    end else if (jump == 2'b01) begin
      w_run_next_pc = jump_addr[PC_WIDTH-1:0];
    end else if (branch && zero) begin
      w_run_next_pc = w_branch_tgt;
    end else begin
      w_run_next_pc = w_pc_plus1;
    end
  end

  // Run-state transitions, PC/ROM-select updates and commit stall.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_rom_sel_nxt = r_rom_sel;
    w_stall       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_stall = halt | input_flag;
        if (halt) begin
          w_state_nxt = S_HALTED;
        end else if (input_flag) begin
          w_state_nxt = S_WAIT_IN;
        end else if (change_rom) begin
          w_rom_sel_nxt = reg_target[ROM_SEL_WIDTH-1:0];
          w_pc_nxt      = {PC_WIDTH{1'b0}};
          w_state_nxt   = S_ROM_BUBBLE;
        end else begin
          w_pc_nxt = w_run_next_pc;
        end
      end
      S_WAIT_IN: begin
        w_stall = 1'b1;
        if (w_confirm_edge) begin
          w_state_nxt = S_IN_COMMIT;
        end else begin
          w_state_nxt = S_WAIT_IN;
        end
      end
      S_IN_COMMIT: begin
        w_stall     = 1'b0;
        w_pc_nxt    = w_pc_plus1;
        w_state_nxt = S_RUN;
      end
      S_ROM_BUBBLE: begin
        w_stall     = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_HALTED: begin
        w_stall = 1'b1;
      end
      default: begin
        w_stall     = 1'b1;
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // State, PC and ROM-select registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_pc      <= {PC_WIDTH{1'b0}};
      r_rom_sel <= {ROM_SEL_WIDTH{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_rom_sel <= w_rom_sel_nxt;
    end
  end

  assign pc            = r_pc;
  assign pc_plus1      = w_pc_plus1;
  assign rom_sel       = r_rom_sel;
  assign stall         = w_stall;
  assign halted        = (r_state == S_HALTED);
  assign waiting_input = (r_state == S_WAIT_IN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  jump = 2'b00;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        halt = 1'b0;
  logic        input_flag = 1'b0;
  logic        change_rom = 1'b0;
  logic [15:0] imm = 16'h0000;
  logic [25:0] jump_addr = 26'h0;
  logic [31:0] reg_target = 32'h0;
  logic        input_confirm = 1'b0;
  logic [9:0]  pc;
  logic [9:0]  pc_plus1;
  logic [3:0]  rom_sel;
  logic        stall;
  logic        halted;
  logic        waiting_input;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(.PC_WIDTH(10), .ROM_SEL_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .jump(jump), .branch(branch), .zero(zero),
    .halt(halt), .input_flag(input_flag), .change_rom(change_rom), .imm(imm),
    .jump_addr(jump_addr), .reg_target(reg_target), .input_confirm(input_confirm),
    .pc(pc), .pc_plus1(pc_plus1), .rom_sel(rom_sel), .stall(stall),
    .halted(halted), .waiting_input(waiting_input)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_pc", pc, 0); chk("rst_rom", rom_sel, 0); chk("rst_stall", stall, 0);
    chk("rst_halted", halted, 0); chk("rst_wait", waiting_input, 0);
    chk("rst_pcp1", pc_plus1, 1);

    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", pc, i); chk("seq_pcp1", pc_plus1, i + 1); chk("seq_stall", stall, 0);
    end
    step();
    chk("seq_pc5", pc, 5);

    // Taken branch with negative offset: 5 + 1 - 3 = 3
    branch = 1'b1; zero = 1'b1; imm = 16'hFFFD;
    step();
    chk("br_taken", pc, 3);
    branch = 1'b0; zero = 1'b0;
    step(); step();
    chk("br_back5", pc, 5);
    branch = 1'b1; zero = 1'b0;
    step();
    chk("br_not_taken", pc, 6);
    branch = 1'b0;

    jump = 2'b01; jump_addr = 26'd1023;
    step();
    chk("pc_max", pc, 1023); chk("pcp1_wrap", pc_plus1, 0);
    jump = 2'b00;
    step();
    chk("pc_wrap", pc, 0);

    jump = 2'b01; jump_addr = 26'd7;
    step();
    chk("j_to7", pc, 7);
    jump_addr = 26'h2A5;
    step();
    chk("j_abs", pc, 32'h2A5);
    jump = 2'b10; reg_target = 32'h0000_0123;
    step();
    chk("jr", pc, 32'h123);
    reg_target = 32'h0000_00AB; branch = 1'b1; zero = 1'b1; imm = 16'h0005;
    step();
    chk("jr_over_br", pc, 32'hAB);
    jump = 2'b11; branch = 1'b0; zero = 1'b0;
    step();
    chk("j11_seq", pc, 32'hAC);

    // Input handshake at pc=9
    jump = 2'b01; jump_addr = 26'd9;
    step();
    jump = 2'b00;
    chk("in_pc9", pc, 9);
    input_flag = 1'b1;
    #1;
    chk("in_run_stall", stall, 1); chk("in_run_wait", waiting_input, 0);
    step();
    chk("in_wait", waiting_input, 1); chk("in_stall", stall, 1); chk("in_pc", pc, 9);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("in_hold_pc", pc, 9); chk("in_hold_wait", waiting_input, 1);
    end
    input_confirm = 1'b1;
    step();
    chk("cf_e1", waiting_input, 1);
    step();
    chk("cf_e2", waiting_input, 1); chk("cf_e2_stall", stall, 1);
    step();
    chk("cf_commit_wait", waiting_input, 0); chk("cf_commit_stall", stall, 0);
    chk("cf_commit_pc", pc, 9);
    input_confirm = 1'b0; input_flag = 1'b0;
    step();
    chk("cf_pc10", pc, 10); chk("cf_run_stall", stall, 0);

    // Confirm held before entering WAIT_IN needs a re-press
    input_confirm = 1'b1;
    step(); step(); step();
    chk("held_pc13", pc, 13);
    input_flag = 1'b1;
    step();
    chk("held_wait", waiting_input, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_nowake", waiting_input, 1); chk("held_pc", pc, 13);
    end
    input_confirm = 1'b0;
    step(); step(); step();
    chk("rel_wait", waiting_input, 1);
    input_confirm = 1'b1;
    step(); step();
    chk("repress_wait", waiting_input, 1);
    step();
    chk("repress_commit", waiting_input, 0); chk("repress_stall", stall, 0);
    input_flag = 1'b0; input_confirm = 1'b0;
    step();
    chk("repress_pc14", pc, 14);

    // ROM change at pc=40
    jump = 2'b01; jump_addr = 26'd40;
    step();
    chk("rom_pc40", pc, 40);
    jump = 2'b11; change_rom = 1'b1; reg_target = 32'h0000_0005;
    step();
    jump = 2'b00; change_rom = 1'b0; reg_target = 32'h0;
    #1;
    chk("rom_sel5", rom_sel, 5); chk("rom_pc0", pc, 0); chk("rom_bubble_stall", stall, 1);
    step();
    chk("rom_run_pc0", pc, 0); chk("rom_run_stall", stall, 0);
    step();
    chk("rom_pc1", pc, 1);
    step();
    chk("rom_pc2", pc, 2); chk("rom_sel_keep", rom_sel, 5);

    // Halt beats input_flag at pc=12
    jump = 2'b01; jump_addr = 26'd12;
    step();
    jump = 2'b00;
    halt = 1'b1; input_flag = 1'b1;
    #1;
    chk("halt_run_stall", stall, 1);
    step();
    halt = 1'b0; input_flag = 1'b0;
    #1;
    chk("halt_halted", halted, 1); chk("halt_nowait", waiting_input, 0);
    chk("halt_pc", pc, 12); chk("halt_stall", stall, 1);
    input_confirm = 1'b1;
    repeat (4) step();
    input_confirm = 1'b0;
    repeat (3) step();
    chk("halt_frozen_pc", pc, 12); chk("halt_frozen", halted, 1); chk("halt_rom", rom_sel, 5);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", pc, 0); chk("arst_halted", halted, 0); chk("arst_rom", rom_sel, 0);
    chk("arst_stall", stall, 0); chk("arst_wait", waiting_input, 0);
    #1 reset = 1'b0;
    step();
    chk("arst_run_pc1", pc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch-sequencing stage directly downstream of the control unit.
- Consumes the decoded Jump/Branch/halt/input_flag/changeROM controls plus datapath operands, and produces the next instruction address and the ROM bank select.
- Owns processor run state: running, waiting for user input, ROM-switch bubble, halted.
- Drives a stall signal the datapath uses to gate regWrite/memWrite (commit enable = ~stall).

Parameters:
PC_WIDTH, 10, width of the instruction address / PC register
ROM_SEL_WIDTH, 4, width of the ROM bank select register

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
jump  input  2  from control unit: 00 sequential, 01 absolute jump, 10 jump-register, 11 ROM change
branch  input  1  from control unit: conditional branch instruction
zero  input  1  ALU zero flag for the current instruction
halt  input  1  from control unit: HALT opcode
input_flag  input  1  from control unit: input instruction
change_rom  input  1  from control unit: changeROM opcode
imm  input  16  branch offset in instructions, signed
jump_addr  input  26  J-type target field
reg_target  input  32  rs register value (jr target / new ROM id)
input_confirm  input  1  asynchronous user confirm button, active-high level
pc  output  PC_WIDTH  current instruction address (registered)
pc_plus1  output  PC_WIDTH  pc+1 mod 2^PC_WIDTH, combinational, used as the jal link value
rom_sel  output  ROM_SEL_WIDTH  active ROM bank (registered)
stall  output  1  1 = current instruction must not commit
halted  output  1  1 in HALTED state
waiting_input  output  1  1 in WAIT_IN state

Behaviour:
- Reset (async, immediate): pc=0, rom_sel=0, state=RUN, synchronizer and edge registers=0. Resulting outputs: stall=0, halted=0, waiting_input=0.
- input_confirm path:
  - 2-FF synchronizer, then edge register; confirm_edge = sync2 & ~edge_q.
  - If input_confirm rises before clock edge k, confirm_edge is high during the cycle after edge k+1.
  - Edges are ignored in every state except WAIT_IN.
- Next-PC in RUN, in priority order:
  - jump==10 -> reg_target[PC_WIDTH-1:0]
  - jump==01 -> jump_addr[PC_WIDTH-1:0]
  - branch&zero -> pc+1+sext(imm), truncated mod 2^PC_WIDTH
  - otherwise pc+1, so jump==11 without change_rom behaves as sequential.
  - All arithmetic is modulo 2^PC_WIDTH: the max address wraps to 0, and negative offsets wrap.
- States:
  - RUN:
    - halt=1 -> HALTED, pc holds. halt has priority over every other control.
    - else input_flag=1 -> WAIT_IN, pc holds.
    - else change_rom=1 -> rom_sel<=reg_target[ROM_SEL_WIDTH-1:0], pc<=0, -> ROM_BUBBLE.
    - else pc<=next-PC.
    - stall = halt | input_flag, combinational within RUN.
  - WAIT_IN:
    - pc holds, stall=1, waiting_input=1.
    - confirm_edge -> IN_COMMIT.
    - If the button is already held when WAIT_IN is entered, no edge exists; it must be released and pressed again.
  - IN_COMMIT:
    - One cycle, stall=0 so the input register write commits.
    - pc<=pc+1, -> RUN.
    - input_flag (still high) is ignored in this state.
  - ROM_BUBBLE:
    - One cycle, stall=1, pc holds at 0, covers new-bank read latency.
    - -> RUN.
  - HALTED:
    - stall=1, halted=1, pc and rom_sel frozen.
    - Exit only via reset.
- pc_plus1 always reflects the registered pc, including in stall states.
- Reset asserted mid-WAIT_IN, mid-bubble or while HALTED returns to RUN with pc=0 and rom_sel=0 immediately; there is no pending-state carryover.
- No combinational path from input_confirm to any output.

Test Plan:
- Reset then 4 cycles of jump=00, branch=0 -> pc sequence 0,1,2,3,4; stall=0; pc_plus1 = pc+1 each cycle.
- At pc=5: branch=1, zero=1, imm=-3 -> pc=3 next cycle. At pc=5: branch=1, zero=0 -> pc=6. At pc=1023 (PC_WIDTH=10), sequential -> pc=0.
- Jump handling:
  - pc=7, jump=01, jump_addr=0x2A5 -> pc=0x2A5.
  - jump=10, reg_target=0x0000_0123 -> pc=0x123.
  - jump=10, branch=1, zero=1 in the same cycle -> register target wins.
- Input handshake:
  - At pc=9, input_flag=1 -> waiting_input=1, stall=1, pc stays 9 for 20 cycles.
  - Pulse input_confirm -> IN_COMMIT entered 3 edges later, stall=0 for exactly one cycle, then pc=10.
  - Confirm held high before entry -> no exit until re-press.
- ROM change: change_rom=1, jump=11, reg_target=0x5 at pc=40 -> rom_sel=5, pc=0, stall=1 for one cycle, then pc counts 1,2,...
- Halt: halt=1 with input_flag=1 at pc=12 -> HALTED (not WAIT_IN), pc frozen at 12, confirm pulses ignored. Async reset pulse mid-cycle -> pc=0, halted=0 before the next clock edge.
